// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the ARM pipeline.
// Holds the PC, drives the combinational instruction ROM, and loads the
// fetched word plus PC+4 into the IF/ID pipeline register. The IF/ID
// instruction is also split into the fields used by control_unit and ID.
//
// Optional build macro: IF_PERF_CNT_EN
//   defined   -> saturating fetch_count / flush_count counters
//   undefined -> no counter registers, both count outputs tied to zero
//
// Handshake: there is no valid/ready pair here. LE=0 is a stall request
// from the hazard unit: PC and IF/ID hold. branch_taken=1 is a redirect
// from ID. It overrides a stall, flushes IF/ID to NOP_WORD and clears
// if_valid. if_valid=1 means that IF/ID holds a real instruction.
module fetch_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     PC_STEP     = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Clr,
    input  logic                   LE,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic [PC_WIDTH-1:0]    rom_addr,
    output logic [INSTR_WIDTH-1:0] I31_0,
    output logic [PC_WIDTH-1:0]    output_NextPC,
    output logic                   if_valid,
    output logic [3:0]             I31_28,
    output logic [3:0]             I19_16,
    output logic [3:0]             I15_12,
    output logic [3:0]             I3_0,
    output logic [11:0]            I11_0,
    output logic [23:0]            I23_0,
    output logic [1:0]             fetch_state,
    output logic [CNT_WIDTH-1:0]   fetch_count,
    output logic [CNT_WIDTH-1:0]   flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    next_pc_q;
    logic                   valid_q;
    state_t                 state_q;

    logic [PC_WIDTH-1:0]    pc_plus;
    logic [PC_WIDTH-1:0]    target_aligned;
    logic                   do_flush;
    logic                   do_fetch;

    // Next sequential PC wraps modulo 2^PC_WIDTH; branch targets are forced word-aligned.
    always_comb begin
        pc_plus        = pc_q + STEP;
        target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
        do_flush       = branch_taken;
        do_fetch       = !branch_taken && LE;
    end

    // PC, IF/ID register and fetch FSM: redirect beats stall, stall beats fetch.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pc_q      <= '0;
            instr_q   <= NOP_WORD;
            next_pc_q <= '0;
            valid_q   <= 1'b0;
            state_q   <= RUN;
        end else if (do_flush) begin
            pc_q      <= target_aligned;
            instr_q   <= NOP_WORD;
            next_pc_q <= '0;
            valid_q   <= 1'b0;
            state_q   <= FLUSH;
        end else if (!LE) begin
            state_q   <= STALL;
        end else begin
            pc_q      <= pc_plus;
            instr_q   <= rom_data;
            next_pc_q <= pc_plus;
            valid_q   <= 1'b1;
            state_q   <= RUN;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] fetch_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // Saturating performance counters for latched instructions and flushes.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (do_fetch && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            if (do_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

    assign rom_addr      = pc_q;
    assign I31_0         = instr_q;
    assign output_NextPC = next_pc_q;
    assign if_valid      = valid_q;
    assign fetch_state   = state_q;

    // The decoded fields are plain slices of the registered word, so they add no latency.
    assign I31_28 = instr_q[31:28];
    assign I19_16 = instr_q[19:16];
    assign I15_12 = instr_q[15:12];
    assign I3_0   = instr_q[3:0];
    assign I11_0  = instr_q[11:0];
    assign I23_0  = instr_q[23:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage.
// The ROM model returns the test program at words 0..2 and the value
// 32'hC0DE_0000 | word_index at every other word.
module tb_fetch_stage;

    logic        Clk;
    logic        Clr;
    logic        LE;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [31:0] rom_data;
    logic [7:0]  rom_addr;
    logic [31:0] I31_0;
    logic [7:0]  output_NextPC;
    logic        if_valid;
    logic [3:0]  I31_28;
    logic [3:0]  I19_16;
    logic [3:0]  I15_12;
    logic [3:0]  I3_0;
    logic [11:0] I11_0;
    logic [23:0] I23_0;
    logic [1:0]  fetch_state;
    logic [15:0] fetch_count;
    logic [15:0] flush_count;

    int checks;
    int failures;

    fetch_stage dut (
        .Clk           (Clk),
        .Clr           (Clr),
        .LE            (LE),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rom_data      (rom_data),
        .rom_addr      (rom_addr),
        .I31_0         (I31_0),
        .output_NextPC (output_NextPC),
        .if_valid      (if_valid),
        .I31_28        (I31_28),
        .I19_16        (I19_16),
        .I15_12        (I15_12),
        .I3_0          (I3_0),
        .I11_0         (I11_0),
        .I23_0         (I23_0),
        .fetch_state   (fetch_state),
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Combinational ROM model.
    always_comb begin
        case (rom_addr[7:2])
            6'd0:    rom_data = 32'hE081_0002;
            6'd1:    rom_data = 32'hE241_1001;
            6'd2:    rom_data = 32'hEA00_0003;
            default: rom_data = 32'hC0DE_0000 | {26'd0, rom_addr[7:2]};
        endcase
    end

    typedef struct {
        logic        le;
        logic        br;
        logic [7:0]  tgt;
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [7:0]  npc;
        logic        valid;
        logic [1:0]  st;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int exp_fetch;
    int exp_flush;

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef IF_PERF_CNT_EN
        return n[15:0];
`else
        return (n > 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] pc, input logic [31:0] instr,
                             input logic [7:0] npc, input logic valid, input logic [1:0] st);
        check({tag, " rom_addr"},      {24'd0, rom_addr},      {24'd0, pc});
        check({tag, " I31_0"},         I31_0,                  instr);
        check({tag, " output_NextPC"}, {24'd0, output_NextPC}, {24'd0, npc});
        check({tag, " if_valid"},      {31'd0, if_valid},      {31'd0, valid});
        check({tag, " fetch_state"},   {30'd0, fetch_state},   {30'd0, st});
        check({tag, " I31_28"},        {28'd0, I31_28},        {28'd0, instr[31:28]});
        check({tag, " I19_16"},        {28'd0, I19_16},        {28'd0, instr[19:16]});
        check({tag, " I15_12"},        {28'd0, I15_12},        {28'd0, instr[15:12]});
        check({tag, " I3_0"},          {28'd0, I3_0},          {28'd0, instr[3:0]});
        check({tag, " I11_0"},         {20'd0, I11_0},         {20'd0, instr[11:0]});
        check({tag, " I23_0"},         {8'd0, I23_0},          {8'd0, instr[23:0]});
        check({tag, " fetch_count"},   {16'd0, fetch_count},   {16'd0, cnt_exp(exp_fetch)});
        check({tag, " flush_count"},   {16'd0, flush_count},   {16'd0, cnt_exp(exp_flush)});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_fetch = 0;
        exp_flush = 0;

        //            le br tgt    pc     instr          npc    v  state
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h04, 32'hE0810002, 8'h04, 1'b1, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h08, 32'hE2411001, 8'h08, 1'b1, 2'b00};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h0C, 32'hEA000003, 8'h0C, 1'b1, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h0C, 32'hEA000003, 8'h0C, 1'b1, 2'b01};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h0C, 32'hEA000003, 8'h0C, 1'b1, 2'b01};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h10, 32'hC0DE0003, 8'h10, 1'b1, 2'b00};
        vecs[6]  = '{1'b1, 1'b1, 8'h42, 8'h40, 32'h00000000, 8'h00, 1'b0, 2'b10};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h44, 32'hC0DE0010, 8'h44, 1'b1, 2'b00};
        vecs[8]  = '{1'b0, 1'b1, 8'h20, 8'h20, 32'h00000000, 8'h00, 1'b0, 2'b10};
        vecs[9]  = '{1'b1, 1'b1, 8'h33, 8'h30, 32'h00000000, 8'h00, 1'b0, 2'b10};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h30, 32'h00000000, 8'h00, 1'b0, 2'b01};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h34, 32'hC0DE000C, 8'h34, 1'b1, 2'b00};
        vecs[12] = '{1'b1, 1'b1, 8'hFF, 8'hFC, 32'h00000000, 8'h00, 1'b0, 2'b10};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h00, 32'hC0DE003F, 8'h00, 1'b1, 2'b00};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 8'h04, 32'hE0810002, 8'h04, 1'b1, 2'b00};

        // Reset is held across two edges, then the reset state is checked.
        Clr           = 1'b1;
        LE            = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_all("reset", 8'h00, 32'h0, 8'h00, 1'b0, 2'b00);
        Clr = 1'b0;

        // Table-driven sequence: drive inputs on negedge, check on the next negedge.
        for (int i = 0; i < NVEC; i++) begin
            LE            = vecs[i].le;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            if (vecs[i].br) exp_flush++;
            else if (vecs[i].le) exp_fetch++;
            @(posedge Clk);
            @(negedge Clk);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr,
                      vecs[i].npc, vecs[i].valid, vecs[i].st);
            if (i == 7) begin
                check("cnt_after_t3 fetch", {16'd0, fetch_count}, {16'd0, cnt_exp(5)});
                check("cnt_after_t3 flush", {16'd0, flush_count}, {16'd0, cnt_exp(1)});
            end
        end

        // Clr is raised between edges; every output must clear with no clock edge.
        LE           = 1'b1;
        branch_taken = 1'b0;
        #2;
        Clr = 1'b1;
        #1;
        exp_fetch = 0;
        exp_flush = 0;
        check_all("async_clr", 8'h00, 32'h0, 8'h00, 1'b0, 2'b00);

        // After reset is released, fetching restarts from address 0.
        @(negedge Clk);
        Clr = 1'b0;
        exp_fetch = 1;
        @(posedge Clk);
        @(negedge Clk);
        check_all("post_clr", 8'h04, 32'hE0810002, 8'h04, 1'b1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
